frame_scan_ctrl: RTL
====================

# frame_scan_ctrl

Sequencer that drives the grid renderer's pixel address inputs and streams the returned RGB565 pixels into the LCD frame buffer write port. It sits between the game manager and the frame buffer/LCD writer. It scans the 128×160 screen in row-major order, once per start request, and absorbs write-port backpressure without dropping or duplicating pixels. It also emits a frame-start pulse so the game manager can freeze its Row1..Row8 snapshot for the whole scan.

## Interface
Parameters:
- WIDTH, 128, pixels per line (x range 0..WIDTH-1)
- HEIGHT, 160, lines per frame (y range 0..HEIGHT-1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame request, level-sampled each clk edge
- busy  out  1  high while a frame is in progress
- frame_start  out  1  one-cycle pulse when a frame begins
- done  out  1  one-cycle pulse when the last pixel write is accepted
- ram_addr_x  out  8  renderer x address
- ram_addr_y  out  8  renderer y address
- pix_in  in  16  renderer pixel; registered in the renderer, valid one cycle after the address
- wr_en  out  1  write request to the frame buffer
- wr_addr  out  15  y*WIDTH + x of the pixel on wr_data
- wr_data  out  16  pixel value
- wr_ready  in  1  frame buffer accepts a write when wr_en && wr_ready

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN: on start=1, or when the pending flag is set. On entry, frame_start pulses, busy rises, address counter = (0,0).
- RUN: presents one address per issue cycle, x innermost. After (WIDTH-1, y), the next address is (0, y+1). After (WIDTH-1, HEIGHT-1), go to DRAIN and stop issuing.
- DRAIN → IDLE: when the final pixel write is accepted. done pulses in that cycle; busy falls in the same cycle.
- Pipeline:
  - The address issued in cycle c returns as pix_in in cycle c+1 and is pushed, tagged with its (x,y), into a 2-entry output buffer.
  - The buffer head drives wr_en, wr_addr and wr_data. wr_en = buffer non-empty.
- Credit rule:
  - Credits = 2 − (buffer occupancy + in-flight issues).
  - An issue occurs only if credits > 0, counting a same-cycle accept as a returned credit.
  - With wr_ready held at 1, throughput is 1 pixel/cycle.
  - When not issuing, ram_addr holds its last value.
- Ordering: writes leave in strict scan order. Every pixel is written exactly once per frame.
- wr_addr arithmetic: y*WIDTH + x, computed in 15 bits. Maximum value is 20479; no wrap.
- start while busy sets a single pending flag; further requests are absorbed. The next frame begins the cycle after done. The pending flag clears on frame_start.
- While wr_en=1 and wr_ready=0, wr_en, wr_addr and wr_data stay stable.
- Reset, including mid-frame: state = IDLE and the buffer, credits and pending flag are cleared. In-flight pixels are discarded; no partial frame resumes.
- Reset values: busy=0, frame_start=0, done=0, wr_en=0, wr_addr=0, wr_data=0, ram_addr_x=0, ram_addr_y=0.
- In IDLE, ram_addr_x and ram_addr_y are 0.

## Timing
- start sampled high at edge E0:
  - After E0: frame_start=1 for one cycle, busy=1, address (0,0).
  - After E1: pix_in = pixel(0,0).
  - After E2: wr_en=1, wr_addr=0.
- With continuous wr_ready=1:
  - The write at E2+k is accepted at edge E3+k.
  - The last pixel (127,159), wr_addr 20479, is accepted at E20482.
  - done=1 and busy=0 after E20482.
  - frame_start, busy, done and all write outputs are registered.
- A wr_ready=0 stall of n cycles delays done by exactly n cycles.
- Once the buffer is full, address issue stops within one cycle.
- Back-to-back frames (pending set): the next frame_start occurs the cycle after done.

## Test plan
- Single frame, wr_ready=1: start pulse at E0 → exactly 20480 writes with wr_addr 0..20479 in order, each wr_data equal to the renderer output for its address; done only after E20482; busy low after.
- Random wr_ready (50%) with a scoreboard on renderer pixels → no pixel lost or duplicated, wr_addr/wr_data stable while stalled, done delayed by exactly the number of stall cycles.
- wr_ready=0 held for 10 cycles at pixel (127,0) → the wr_addr=127 write is held stable; next write after release is wr_addr 128, pixel (0,1); at most 2 addresses issued past the stall point.
- start asserted three times during a frame → exactly one extra frame; its frame_start falls the cycle after the first done; two frames total.
- rst asserted at pixel ~5000 → all outputs return to reset values immediately; a subsequent start produces a clean frame beginning at wr_addr 0.
- start held continuously high → frames repeat back-to-back; frame_start pulses once per frame, one cycle after each done.

Source files
------------

// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: row-major frame scanner feeding renderer pixels into the frame buffer write port
module frame_scan_ctrl #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        frame_start,
    output logic        done,
    output logic [7:0]  ram_addr_x,
    output logic [7:0]  ram_addr_y,
    input  logic [15:0] pix_in,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [15:0] wr_data,
    input  logic        wr_ready
);
    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  RUN   = 2'd1;
    localparam logic [1:0]  DRAIN = 2'd2;
    localparam logic [14:0] LAST  = 15'(WIDTH * HEIGHT - 1);
    localparam logic [7:0]  XMAX  = 8'(WIDTH - 1);
    localparam logic [7:0]  YMAX  = 8'(HEIGHT - 1);

    logic [1:0]  state_q, state_d;
    logic        busy_q, busy_d, fs_q, fs_d, done_q, done_d, pend_q, pend_d;
    logic [7:0]  ax_q, ax_d, ay_q, ay_d, ptx_q, pty_q;
    logic        aval_q, aval_d, pval_q, pval_d, en_q, en_d;
    logic [1:0]  occ_q, occ_d, occ_a;
    logic [14:0] b0a_q, b0a_d, b1a_q, b1a_d, new_addr;
    logic [15:0] b0d_q, b0d_d, b1d_q, b1d_d;
    logic        pop, push, room, last_iss, fin;

    assign busy        = busy_q;
    assign frame_start = fs_q;
    assign done        = done_q;
    assign ram_addr_x  = ax_q;
    assign ram_addr_y  = ay_q;
    assign wr_en       = en_q;
    assign wr_addr     = b0a_q;
    assign wr_data     = b0d_q;

    // Output buffer: pop the head on accept, push the returning pixel into the first free slot.
    // A pixel that finds the buffer full is left on pix_in: issue is then blocked, so the
    // renderer keeps presenting it until a slot opens.
    always_comb begin
        pop      = en_q && wr_ready;
        occ_a    = occ_q - {1'b0, pop};
        push     = pval_q && occ_a != 2'd2;
        new_addr = 15'(pty_q) * 15'(WIDTH) + 15'(ptx_q);
        b0a_d    = (push && occ_a == 2'd0) ? new_addr : (pop ? b1a_q : b0a_q);
        b0d_d    = (push && occ_a == 2'd0) ? pix_in : (pop ? b1d_q : b0d_q);
        b1a_d    = (push && occ_a == 2'd1) ? new_addr : b1a_q;
        b1d_d    = (push && occ_a == 2'd1) ? pix_in : b1d_q;
        occ_d    = occ_a + {1'b0, push};
        en_d     = occ_d != 2'd0;
        pval_d   = aval_q || (pval_q && !push);
        room     = !(pval_d && occ_d == 2'd2);
        last_iss = ax_q == XMAX && ay_q == YMAX;
        fin      = pop && b0a_q == LAST;
    end

    // Frame sequencing and address issue; a start seen while busy is remembered in pend.
    always_comb begin
        state_d = state_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        aval_d  = 1'b0;
        fs_d    = 1'b0;
        done_d  = 1'b0;
        pend_d  = pend_q || (start && state_q != IDLE);
        case (state_q)
            IDLE: if (start || pend_q) begin
                state_d = RUN;
                fs_d    = 1'b1;
                pend_d  = 1'b0;
                aval_d  = 1'b1;
                ax_d    = 8'd0;
                ay_d    = 8'd0;
            end
            RUN: if (last_iss) begin
                state_d = DRAIN;
            end else if (room) begin
                aval_d = 1'b1;
                ax_d   = ax_q == XMAX ? 8'd0 : ax_q + 8'd1;
                ay_d   = ax_q == XMAX ? ay_q + 8'd1 : ay_q;
            end
            DRAIN: if (fin) begin
                state_d = IDLE;
                done_d  = 1'b1;
                ax_d    = 8'd0;
                ay_d    = 8'd0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    // State registers; reset discards any partially scanned frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
            ax_q    <= 8'd0;
            ay_q    <= 8'd0;
            ptx_q   <= 8'd0;
            pty_q   <= 8'd0;
            aval_q  <= 1'b0;
            pval_q  <= 1'b0;
            en_q    <= 1'b0;
            occ_q   <= 2'd0;
            b0a_q   <= 15'd0;
            b0d_q   <= 16'd0;
            b1a_q   <= 15'd0;
            b1d_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            ptx_q   <= ax_q;
            pty_q   <= ay_q;
            aval_q  <= aval_d;
            pval_q  <= pval_d;
            en_q    <= en_d;
            occ_q   <= occ_d;
            b0a_q   <= b0a_d;
            b0d_q   <= b0d_d;
            b1a_q   <= b1a_d;
            b1d_q   <= b1d_d;
        end
    end
endmodule
